// File: rtl/ht_pkg.sv
// ht_pkg: shared definitions for the ht sorter front-end.
//   - ht_state_e : controller state encoding (FILL, RUN, DRAIN)
//   - HT_*       : default job geometry and watchdog limit
//   - elem_lsb() : bit offset of element idx inside an INDEX*WIDTH flattened
//                  vector; used both to pack (write) and unpack (read) elements.
package ht_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ht_state_e;

    localparam int HT_INDEX   = 8;
    localparam int HT_WIDTH   = 5;
    localparam int HT_TIMEOUT = 64;

    function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ht_wdog.sv
// ht_wdog: watchdog counter for the RUN phase.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (higher priority than en)
//   en       : increment count; holds once expired so it never wraps
//   expired  : count has reached TIMEOUT-1
module ht_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] cnt;

    assign expired = (cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ht_stream_ctrl.sv
// ht_stream_ctrl: stream front-end and sequencer for the ht parallel sorter.
// Collects INDEX elements into a load buffer, holds ht_start until ht_over,
// captures the sorted vector and replays it ascending on the output stream.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_data   : input element stream (accepted in FILL)
//   out_valid/out_ready/out_data/out_last : sorted output stream (DRAIN)
//   ht_start, ht_indata         : start level and load buffer to ht
//   ht_outdata, ht_over         : sorted vector and done level from ht
//   busy                        : RUN or DRAIN
//   err_timeout                 : one-cycle pulse when the watchdog aborts a job
module ht_stream_ctrl
    import ht_pkg::*;
#(
    parameter int INDEX   = HT_INDEX,
    parameter int WIDTH   = HT_WIDTH,
    parameter int TIMEOUT = HT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic                   ht_start,
    output logic [INDEX*WIDTH-1:0] ht_indata,
    input  logic [INDEX*WIDTH-1:0] ht_outdata,
    input  logic                   ht_over,
    output logic                   busy,
    output logic                   err_timeout
);
    localparam int         IW   = $clog2(INDEX);
    localparam logic [IW-1:0] LAST = IW'(INDEX - 1);

    ht_state_e state, state_nxt;

    logic [IW-1:0]          wr_idx, rd_idx;
    logic [INDEX*WIDTH-1:0] lbuf, obuf;
    logic                   expired;

    ht_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != RUN),
        .en      (state == RUN),
        .expired (expired)
    );

    // Every output is a decode of registered state/indices/buffers.
    assign in_ready  = (state == FILL) && !rst;
    assign ht_start  = (state == RUN);
    assign busy      = (state != FILL);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (rd_idx == LAST);
    assign out_data  = obuf[elem_lsb(32'(rd_idx), WIDTH) +: WIDTH];
    assign ht_indata = lbuf;

    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (in_valid && in_ready && wr_idx == LAST) state_nxt = RUN;
            RUN:     if (ht_over)                                state_nxt = DRAIN;
                     else if (expired)                           state_nxt = FILL;
            DRAIN:   if (out_ready && rd_idx == LAST)            state_nxt = FILL;
            default:                                             state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            lbuf        <= '0;
            obuf        <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                FILL: if (in_valid) begin
                    lbuf[elem_lsb(32'(wr_idx), WIDTH) +: WIDTH] <= in_data;
                    wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
                end
                RUN: begin
                    // ht_over takes priority over a same-cycle expiry.
                    if (ht_over) begin
                        obuf   <= ht_outdata;
                        rd_idx <= '0;
                    end else if (expired) begin
                        err_timeout <= 1'b1;
                        wr_idx      <= '0;
                    end
                end
                DRAIN: if (out_ready)
                    rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ht_stream_ctrl.sv
module tb_ht_stream_ctrl;
    localparam int INDEX = 8, WIDTH = 5, TIMEOUT = 64;

    logic                   clk = 1'b0;
    logic                   rst, in_valid, out_ready, ht_over;
    logic [WIDTH-1:0]       in_data;
    logic [INDEX*WIDTH-1:0] ht_outdata;
    logic                   in_ready, out_valid, out_last, ht_start, busy, err_timeout;
    logic [WIDTH-1:0]       out_data;
    logic [INDEX*WIDTH-1:0] ht_indata;

    int checks = 0;
    int errors = 0;

    typedef logic [WIDTH-1:0] elem_t;
    elem_t job_a [8] = '{5'd9, 5'd3, 5'd31, 5'd0, 5'd7, 5'd7, 5'd12, 5'd1};
    elem_t srt_a [8] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd7, 5'd9, 5'd12, 5'd31};
    elem_t job_c [8] = '{5'd20, 5'd4, 5'd4, 5'd17, 5'd0, 5'd30, 5'd2, 5'd9};
    elem_t srt_c [8] = '{5'd0, 5'd2, 5'd4, 5'd4, 5'd9, 5'd17, 5'd20, 5'd30};
    elem_t all31 [8] = '{default: 5'd31};
    elem_t zeros [8] = '{default: 5'd0};

    ht_stream_ctrl #(.INDEX(INDEX), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ht_start(ht_start), .ht_indata(ht_indata), .ht_outdata(ht_outdata), .ht_over(ht_over),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INDEX*WIDTH-1:0] pack(input elem_t d [8]);
        logic [INDEX*WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < INDEX; i++) v[i*WIDTH +: WIDTH] = d[i];
        return v;
    endfunction

    // Stream one job in; gaps inserts idle input cycles before some elements.
    task automatic load_job(input elem_t d [8], input bit gaps);
        for (int i = 0; i < INDEX; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                chk("gap_ready", 64'(in_ready), 64'd1);
                step();
            end
            in_valid = 1'b1;
            in_data  = d[i];
            chk("fill_ready", 64'(in_ready), 64'd1);
            chk("fill_start_low", 64'(ht_start), 64'd0);
            step();
        end
        in_valid = 1'b0;
        chk("run_start", 64'(ht_start), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_ready", 64'(in_ready), 64'd0);
        chk("indata_pack", 64'(ht_indata), 64'(pack(d)));
    endtask

    // ht stand-in: raises over so that ht_start is high for exactly ncyc cycles.
    task automatic run_ht(input int ncyc, input elem_t s [8]);
        for (int k = 1; k < ncyc; k++) begin
            chk("run_hold", 64'(ht_start), 64'd1);
            chk("run_noerr", 64'(err_timeout), 64'd0);
            step();
        end
        ht_over    = 1'b1;
        ht_outdata = pack(s);
        chk("run_last", 64'(ht_start), 64'd1);
        step();
        ht_over = 1'b0;
        chk("drain_start_low", 64'(ht_start), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd1);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_noerr", 64'(err_timeout), 64'd0);
    endtask

    // Take up to nlim outputs; bp applies out_ready pattern 1,0,0,1,0,0,...
    task automatic drain(input elem_t s [8], input bit bp, input int nlim);
        int n, cyc;
        n = 0; cyc = 0;
        while (n < nlim && cyc < 100) begin
            out_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_data", 64'(out_data), 64'(s[n]));
            chk("out_last", 64'(out_last), 64'(n == INDEX - 1));
            step();
            if (out_ready) n++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("out_count", 64'(n), 64'(nlim));
    endtask

    task automatic check_idle();
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_noerr", 64'(err_timeout), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        ht_over = 1'b0; ht_outdata = '0;
        step(); step();
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_start", 64'(ht_start), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_indata", 64'(ht_indata), 64'd0);
        rst = 1'b0;
        #1;
        chk("first_ready", 64'(in_ready), 64'd1);

        // over outside RUN is ignored
        ht_over = 1'b1;
        step();
        ht_over = 1'b0;
        chk("over_in_fill_busy", 64'(busy), 64'd0);
        chk("over_in_fill_valid", 64'(out_valid), 64'd0);

        // basic job
        load_job(job_a, 1'b0);
        run_ht(3, srt_a);
        drain(srt_a, 1'b0, 8);
        check_idle();

        // backpressure with input gaps
        load_job(job_a, 1'b1);
        run_ht(3, srt_a);
        drain(srt_a, 1'b1, 8);
        check_idle();

        // timeout: ht never finishes
        load_job(job_a, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            chk("to_start_high", 64'(ht_start), 64'd1);
            chk("to_noerr_yet", 64'(err_timeout), 64'd0);
            step();
        end
        chk("to_err_pulse", 64'(err_timeout), 64'd1);
        chk("to_ready", 64'(in_ready), 64'd1);
        chk("to_start_low", 64'(ht_start), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        step();
        chk("to_err_once", 64'(err_timeout), 64'd0);
        load_job(job_c, 1'b0);
        run_ht(3, srt_c);
        drain(srt_c, 1'b0, 8);
        check_idle();

        // over arrives in the same cycle as expiry
        load_job(job_a, 1'b0);
        run_ht(TIMEOUT, srt_a);
        drain(srt_a, 1'b0, 8);
        check_idle();

        // reset after three outputs
        load_job(job_c, 1'b0);
        run_ht(2, srt_c);
        drain(srt_c, 1'b0, 3);
        rst = 1'b1;
        step();
        chk("mrst_ready", 64'(in_ready), 64'd0);
        chk("mrst_start", 64'(ht_start), 64'd0);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_data", 64'(out_data), 64'd0);
        chk("mrst_last", 64'(out_last), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_err", 64'(err_timeout), 64'd0);
        rst = 1'b0;
        #1;
        load_job(all31, 1'b0);
        run_ht(1, all31);
        drain(all31, 1'b0, 8);
        check_idle();

        // back-to-back jobs; load_job checks start stays low for all 8 fill cycles
        load_job(job_c, 1'b0);
        run_ht(3, srt_c);
        drain(srt_c, 1'b0, 8);
        load_job(zeros, 1'b0);
        run_ht(3, zeros);
        drain(zeros, 1'b0, 8);
        check_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ht_stream_ctrl.md
# ht_stream_ctrl

Streaming front-end and sequencer for the `ht` parallel sorter. Collects INDEX elements from a valid/ready input stream into a load buffer and drives them onto `ht` as a parallel vector. It holds `start` until `ht` raises `over`, captures the sorted vector, then replays it ascending on a valid/ready output stream. A watchdog aborts a job if `ht` never reports `over`.

## Interface
Parameters:
- INDEX, 8: elements per job (≥2).
- WIDTH, 5: element width in bits.
- TIMEOUT, 64: maximum RUN cycles before abort (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts input element.
- in_data  in  WIDTH  input element.
- out_valid  out  1  sorted element valid.
- out_ready  in  1  downstream accepts sorted element.
- out_data  out  WIDTH  sorted element, ascending order.
- out_last  out  1  marks element INDEX-1 of a job.
- ht_start  out  1  start level to `ht`.
- ht_indata  out  INDEX*WIDTH  load buffer; element i at bits [i*WIDTH +: WIDTH].
- ht_outdata  in  INDEX*WIDTH  sorted vector from `ht`, same packing.
- ht_over  in  1  `ht` done level; qualifies ht_outdata.
- busy  out  1  high in RUN or DRAIN.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: FILL, RUN, DRAIN. Reset state is FILL.
- FILL:
  - in_ready=1.
  - Each in_valid&in_ready writes in_data to lbuf[wr_idx], then wr_idx++.
  - On the handshake with wr_idx==INDEX-1: wr_idx←0, timer←0, go to RUN.
- RUN:
  - ht_start=1, in_ready=0. Timer increments every cycle.
  - If ht_over=1: obuf←ht_outdata, rd_idx←0, go to DRAIN.
  - Else if timer==TIMEOUT-1: err_timeout=1 for exactly one cycle. Discard the job (lbuf contents don't care, wr_idx=0) and go to FILL.
  - ht_over and timeout in the same cycle: ht_over wins, no error.
- DRAIN:
  - out_valid=1, out_data=obuf[rd_idx], out_last=(rd_idx==INDEX-1).
  - Each out_valid&out_ready increments rd_idx.
  - The handshake with out_last=1 returns to FILL.
  - out_data/out_last stay stable while out_valid&~out_ready.
- ht_over is ignored outside RUN.
- `ht` is required to drop over while start is low. The FILL phase lasts ≥INDEX cycles, so start is guaranteed low ≥2 cycles between jobs.
- ht_indata is continuously driven from lbuf. lbuf is not modified during RUN.
- Widths:
  - wr_idx and rd_idx are $clog2(INDEX) bits and never wrap past INDEX-1.
  - timer is $clog2(TIMEOUT) bits and saturates by state exit.
- Equal elements pass through unchanged. The controller performs no comparison itself.

## Timing
- Reset (rst=1 at a clock edge):
  - state=FILL, wr_idx=rd_idx=timer=0.
  - ht_start=0, out_valid=0, out_last=0, out_data=0, busy=0, err_timeout=0.
  - in_ready is forced 0 while rst is high. lbuf/obuf are cleared to 0.
- Reset mid-RUN or mid-DRAIN aborts immediately with no err_timeout. Partial input or output is lost.
- The first in_ready=1 occurs in the cycle after rst falls.
- Last input handshake at edge N: ht_start=1 and busy=1 from cycle N+1.
- ht_over sampled high at edge M: ht_start=0 and out_valid=1 from cycle M+1.
- Minimum ht_start high time is 1 cycle, when ht_over is already high at the first RUN edge.
- Last output handshake at edge K: in_ready=1 and busy=0 from cycle K+1.
- No input/output overlap: in_ready=0 throughout RUN and DRAIN.
- Timeout: the abort edge falls on the TIMEOUT-th RUN cycle. err_timeout is high for the cycle after that edge, with in_ready=1 concurrently.
- All outputs are decoded from registered state/indices. There is no combinational in→out path except none-required; in_ready depends only on state and rst.

## Structure
- Shared package `ht_pkg`: state enum (FILL, RUN, DRAIN), default INDEX/WIDTH/TIMEOUT constants, and a pack/unpack helper for the INDEX*WIDTH flattened vectors.
- One sub-module `ht_wdog`: a loadable counter with clear, enable, and a `expired` compare at TIMEOUT-1, parameterized by TIMEOUT.
- `ht` is not instantiated inside this block; the integration top wires ht_* ports to it.

## Test plan
All scenarios use INDEX=8, WIDTH=5, TIMEOUT=64.
- Basic job:
  - Stimulus: stream 9,3,31,0,7,7,12,1 with in_valid held high; `ht` model asserts over 3 cycles after start.
  - Required: ht_indata packs 9..1 in order; out sequence is 0,1,3,7,7,9,12,31; out_last only on 31; no err_timeout.
- Backpressure:
  - Stimulus: same job; out_ready toggles 1,0,0,1,… and in_valid has random gaps.
  - Required: identical output order; out_data is stable during stalls; exactly 8 output handshakes.
- Timeout:
  - Stimulus: `ht` model never asserts over.
  - Required: ht_start is high for exactly 64 cycles; err_timeout pulses once; in_ready=1 the next cycle; a following job sorts correctly.
- Over/timeout tie:
  - Stimulus: ht_over rises on the 64th RUN cycle.
  - Required: no err_timeout; DRAIN is entered.
- Reset mid-DRAIN:
  - Stimulus: assert rst after 3 outputs.
  - Required: the next cycle shows all outputs at reset values; the next job (31×8) outputs eight 31s.
- Back-to-back jobs:
  - Stimulus: two jobs, the second all zeros.
  - Required: ht_start is low ≥8 cycles between jobs; the second output is eight 0s.
